// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: fetch FSM state encoding, reset PC and instruction width.
package mips_lite_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-side bus bundle: imem request/response, decode handshake, next-PC loop and status.
interface pc_fetch_if;

  logic [mips_lite_pkg::INSTR_W-1:0] npc;
  logic [mips_lite_pkg::INSTR_W-1:0] pc;
  logic                              imem_req_valid;
  logic [mips_lite_pkg::INSTR_W-1:0] imem_req_addr;
  logic                              imem_req_ready;
  logic                              imem_rsp_valid;
  logic [mips_lite_pkg::INSTR_W-1:0] imem_rsp_data;
  logic [mips_lite_pkg::INSTR_W-1:0] instr;
  logic                              instr_valid;
  logic                              instr_ready;
  logic                              fetch_fault;
  logic [mips_lite_pkg::INSTR_W-1:0] instret;

  modport master (
    input  npc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output pc, imem_req_valid, imem_req_addr, instr, instr_valid, fetch_fault, instret
  );

  modport slave (
    output npc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  pc, imem_req_valid, imem_req_addr, instr, instr_valid, fetch_fault, instret
  );

endinterface

// File: rtl/pc_fetch.sv
// MIPS-lite fetch front end: PC register, single-outstanding imem read, instruction buffer.
// PC_FETCH_ALIGN_CHECK_EN: a misaligned npc on accept traps into a sticky FAULT state.
module pc_fetch
  import mips_lite_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = mips_lite_pkg::RESET_PC
) (
  input logic        clk,
  input logic        rst_n,
  pc_fetch_if.master bus
);

  // state | meaning
  // IDLE  | one cycle after reset before the first request
  // REQ   | request at pc presented, waiting for imem_req_ready
  // WAIT  | request accepted, waiting for the response pulse
  // HOLD  | instr valid for decode, waiting for instr_ready
  // FAULT | misaligned npc seen, terminal until reset

  fetch_state_e       r_state;
  fetch_state_e       w_state_nxt;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_instret;
  logic [INSTR_W-1:0] w_pc_nxt;
  logic               w_capture;
  logic               w_retire;

  assign w_pc_nxt = bus.npc & ~(INSTR_W'(3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.imem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.instr_ready) begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
          if (bus.npc[1:0] != 2'b00) begin
            w_state_nxt = ST_FAULT;
          end else begin
            w_retire    = 1'b1;
            w_state_nxt = ST_REQ;
          end
`else
          w_retire    = 1'b1;
          w_state_nxt = ST_REQ;
`endif
        end
      end
`ifdef PC_FETCH_ALIGN_CHECK_EN
      ST_FAULT: w_state_nxt = ST_FAULT;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_instret <= '0;
    end else begin
      if (w_capture) r_instr <= bus.imem_rsp_data;
      if (w_retire) begin
        r_pc      <= w_pc_nxt;
        r_instret <= r_instret + INSTR_W'(1);
      end
    end
  end

  // every output comes straight from a register, never from an input
  assign bus.pc             = r_pc;
  assign bus.imem_req_addr  = r_pc;
  assign bus.imem_req_valid = (r_state == ST_REQ);
  assign bus.instr          = r_instr;
  assign bus.instr_valid    = (r_state == ST_HOLD);
  assign bus.instret        = r_instret;
`ifdef PC_FETCH_ALIGN_CHECK_EN
  assign bus.fetch_fault    = (r_state == ST_FAULT);
`else
  assign bus.fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios then randomized traffic against a transaction-level model.
module tb_pc_fetch;

  logic clk;
  logic rst_n;

  pc_fetch_if u_if ();

  pc_fetch u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: what the front end knows about its single fetch slot
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_instret;
  bit          m_started;
  bit          m_outst;
  bit          m_have;
  bit          m_fault;

  task automatic m_reset();
    m_pc      = 32'h0000_3000;
    m_instr   = 32'h0;
    m_instret = 32'h0;
    m_started = 0;
    m_outst   = 0;
    m_have    = 0;
    m_fault   = 0;
  endtask

  function automatic bit m_req();
    return m_started && !m_outst && !m_have && !m_fault;
  endfunction

  task automatic m_update(input logic rdy, input logic rv, input logic [31:0] rd,
                          input logic ir, input logic [31:0] n);
    if (!m_started) begin
      m_started = 1;
    end else if (m_req() && rdy) begin
      m_outst = 1;
    end else if (m_outst && rv) begin
      m_outst = 0;
      m_have  = 1;
      m_instr = rd;
    end else if (m_have && ir) begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
      if (n[1:0] != 2'b00) begin
        m_fault = 1;
        m_have  = 0;
      end else begin
        m_pc      = {n[31:2], 2'b00};
        m_instret = m_instret + 32'd1;
        m_have    = 0;
      end
`else
      m_pc      = {n[31:2], 2'b00};
      m_instret = m_instret + 32'd1;
      m_have    = 0;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req_valid"},   32'(u_if.imem_req_valid), 32'(m_req()));
    chk({tag, ".req_addr"},    u_if.imem_req_addr,       m_pc);
    chk({tag, ".pc"},          u_if.pc,                  m_pc);
    chk({tag, ".instr"},       u_if.instr,               m_instr);
    chk({tag, ".instr_valid"}, 32'(u_if.instr_valid),    32'(m_have));
    chk({tag, ".fetch_fault"}, 32'(u_if.fetch_fault),    32'(m_fault));
    chk({tag, ".instret"},     u_if.instret,             m_instret);
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic ir, input logic [31:0] n, input string tag);
    u_if.imem_req_ready = rdy;
    u_if.imem_rsp_valid = rv;
    u_if.imem_rsp_data  = rd;
    u_if.instr_ready    = ir;
    u_if.npc            = n;
    if (rst_n) m_update(rdy, rv, rd, ir, n);
    else m_reset();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all("rst_async");
    @(negedge clk);
    check_all("rst");
    rst_n = 1'b1;
  endtask

  logic [31:0] rn;
  int          sel;

  initial begin
    rst_n               = 1'b0;
    u_if.imem_req_ready = 1'b0;
    u_if.imem_rsp_valid = 1'b0;
    u_if.imem_rsp_data  = 32'h0;
    u_if.instr_ready    = 1'b0;
    u_if.npc            = 32'h0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    chk("reset.pc_const", u_if.pc, 32'h0000_3000);

    // streaming: memory always ready, 1-cycle response, sequential npc
    rst_n = 1'b1;
    step(1'b1, 1'b1, 32'hA000_0000, 1'b1, m_pc + 32'd4, "release");
    chk("release.valid_const", 32'(u_if.imem_req_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("stream.addr_const", u_if.imem_req_addr, 32'h0000_3000 + 32'(k) * 32'd4);
      for (int j = 0; j < 3; j++)
        step(1'b1, 1'b1, 32'hA000_0000 + 32'(k * 3 + j), 1'b1, m_pc + 32'd4, "stream");
    end
    chk("stream.addr_end", u_if.imem_req_addr, 32'h0000_300C);
    chk("stream.instret", u_if.instret, 32'd3);

    // memory stalls the request for 4 cycles
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "stall");
      chk("stall.valid_const", 32'(u_if.imem_req_valid), 32'd1);
      chk("stall.addr_const", u_if.imem_req_addr, 32'h0000_300C);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "accept");
    chk("accept.valid_drop", 32'(u_if.imem_req_valid), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "wait");
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "wait");
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, "capture");
    chk("capture.instr_const", u_if.instr, 32'hDEAD_BEEF);

    // decode stalls with npc and stray responses toggling
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, $urandom, 1'b0, $urandom, "hold");
      chk("hold.pc_const", u_if.pc, 32'h0000_300C);
      chk("hold.instr_const", u_if.instr, 32'hDEAD_BEEF);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3010, "hold_accept");
    chk("hold_accept.pc_const", u_if.pc, 32'h0000_3010);

    // spurious response during REQ, then a taken branch
    step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, "spurious");
    chk("spurious.instr_const", u_if.instr, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "br_req");
    step(1'b0, 1'b1, 32'h0000_1111, 1'b0, 32'h0, "br_rsp");
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3040, "branch");
    chk("branch.addr_const", u_if.imem_req_addr, 32'h0000_3040);

    // reset in WAIT, late response after release is dropped
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "pre_rst");
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_mid.pc_async", u_if.pc, 32'h0000_3000);
    chk("rst_mid.instret_async", u_if.instret, 32'd0);
    @(negedge clk);
    check_all("rst_mid");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "rst_rel");
    step(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 32'h0, "late_rsp");
    chk("late_rsp.instr_const", u_if.instr, 32'h0);
    chk("late_rsp.addr_const", u_if.imem_req_addr, 32'h0000_3000);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "mis_req");
    step(1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0, "mis_rsp");

    // misaligned next PC
    step(1'b1, 1'b1, 32'h0, 1'b1, 32'h0000_3042, "misalign");
`ifdef PC_FETCH_ALIGN_CHECK_EN
    chk("misalign.fault_const", 32'(u_if.fetch_fault), 32'd1);
    chk("misalign.pc_const", u_if.pc, 32'h0000_3000);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, $urandom, 1'b1, 32'h0000_3000, "fault_hold");
      chk("fault_hold.no_req", 32'(u_if.imem_req_valid), 32'd0);
    end
`else
    chk("misalign.addr_const", u_if.imem_req_addr, 32'h0000_3040);
    chk("misalign.valid_const", 32'(u_if.imem_req_valid), 32'd1);
`endif
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 60)      rn = m_pc + 32'd4;
      else if (sel < 85) rn = 32'h0000_3000 + 32'($urandom_range(0, 1023)) * 32'd4;
      else               rn = $urandom;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 1)), rn, "rand");
      if (m_fault || $urandom_range(0, 99) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
